// File: rtl/sfifo_wr_arb.sv
// sfifo_wr_arb: burst-locked round-robin arbiter sharing one sfifo write port
// between NREQ producers; a grant holds until last, request drop, or MAXBURST.
module sfifo_wr_arb #(
    parameter int NREQ     = 4,
    parameter int DW       = 8,
    parameter int MAXBURST = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ-1:0]           last,
    input  logic [NREQ*DW-1:0]        data,
    output logic [NREQ-1:0]           ack,
    output logic                      w_en,
    output logic [DW-1:0]             din,
    input  logic                      full,
    input  logic                      overflow,
    output logic [$clog2(NREQ)-1:0]   owner,
    output logic                      busy,
    output logic                      err_ovfl
);
    localparam int OW = $clog2(NREQ);
    localparam int BW = $clog2(MAXBURST + 1);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t        state, state_n;
    logic [OW-1:0] ptr, win;
    logic [BW-1:0] bcnt;
    logic          found, beat, rel;

    // First requesting index strictly after ptr, wrapping modulo NREQ.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && req[(int'(ptr) + k) % NREQ]) begin
                win   = OW'((int'(ptr) + k) % NREQ);
                found = 1'b1;
            end
        end
    end

    assign beat = (state == LOCK) && req[owner] && !full;
    assign rel  = (state == LOCK) &&
                  (!req[owner] || (beat && (last[owner] || bcnt == BW'(MAXBURST - 1))));
    assign w_en = beat;
    assign din  = beat ? data[owner*DW +: DW] : '0;
    assign ack  = beat ? (NREQ'(1) << owner) : '0;
    assign busy = (state == LOCK);

    always_comb begin
        state_n = state;
        state_n = (state == IDLE) ? (|req ? LOCK : IDLE) : (rel ? IDLE : LOCK);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ptr      <= OW'(NREQ - 1);
            owner    <= '0;
            bcnt     <= '0;
            err_ovfl <= 1'b0;
        end else begin
            state    <= state_n;
            err_ovfl <= err_ovfl | overflow;
            if (state == IDLE && |req) begin
                owner <= win;
                bcnt  <= '0;
            end
            if (beat)
                bcnt <= bcnt + 1'b1;
            if (rel)
                ptr <= owner;
        end
    end
endmodule

// File: tb/tb_sfifo_wr_arb.sv
// tb_sfifo_wr_arb: directed bench for sfifo_wr_arb with a beat scoreboard.
module tb_sfifo_wr_arb;
    localparam int NREQ = 4, DW = 8, MAXBURST = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NREQ-1:0]   req = '0, last = '0, ack;
    logic [NREQ*DW-1:0] data = '0;
    logic              w_en, full = 1'b0, overflow = 1'b0, busy, err_ovfl;
    logic [DW-1:0]     din;
    logic [1:0]        owner;

    int checks = 0;
    int errors = 0;
    logic [DW+NREQ-1:0] sb[$];

    sfifo_wr_arb #(.NREQ(NREQ), .DW(DW), .MAXBURST(MAXBURST)) dut (
        .clk(clk), .rst(rst), .req(req), .last(last), .data(data), .ack(ack),
        .w_en(w_en), .din(din), .full(full), .overflow(overflow), .owner(owner),
        .busy(busy), .err_ovfl(err_ovfl)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge with inputs set; checks this cycle, returns at next negedge.
    task automatic cyc(input logic eb, input logic [DW-1:0] ed, input logic [NREQ-1:0] ea,
                       input logic ebusy);
        logic [DW+NREQ-1:0] e;
        if (eb) sb.push_back({ed, ea});
        #1;
        chk("w_en", 32'(w_en), 32'(eb));
        chk("busy", 32'(busy), 32'(ebusy));
        chk("wen_while_full", 32'(w_en & full), 32'd0);
        if (w_en === 1'b1) begin
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL sb_underflow observed beat din=%0h expected no beat", din);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("din", 32'(din), 32'(e[DW+NREQ-1:NREQ]));
                chk("ack", 32'(ack), 32'(e[NREQ-1:0]));
            end
        end else begin
            chk("din_idle", 32'(din), 32'd0);
            chk("ack_idle", 32'(ack), 32'd0);
        end
        @(negedge clk);
    endtask

    task automatic setd(input int i, input logic [DW-1:0] v);
        data[i*DW +: DW] = v;
    endtask

    initial begin
        // Reset / idle
        repeat (4) @(negedge clk);
        chk("rst_w_en", 32'(w_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_err", 32'(err_ovfl), 32'd0);
        rst = 1'b1;
        repeat (5) cyc(1'b0, 8'h0, 4'h0, 1'b0);
        chk("idle_owner", 32'(owner), 32'd0);

        // Single burst on requester 2
        req = 4'b0100;
        setd(2, 8'h75);
        cyc(1'b0, 8'h0, 4'h0, 1'b0);
        cyc(1'b1, 8'h75, 4'b0100, 1'b1);
        setd(2, 8'h76);
        cyc(1'b1, 8'h76, 4'b0100, 1'b1);
        setd(2, 8'h77);
        last = 4'b0100;
        cyc(1'b1, 8'h77, 4'b0100, 1'b1);
        req = '0;
        last = '0;
        cyc(1'b0, 8'h0, 4'h0, 1'b0);
        chk("burst_owner", 32'(owner), 32'd2);

        // Round robin: pointer at 2, so grants go 3,0,1,2,3
        req = 4'b1111;
        last = 4'b1111;
        for (int i = 0; i < NREQ; i++) setd(i, 8'hA0 + 8'(i));
        for (int g = 0; g < 5; g++) begin
            cyc(1'b0, 8'h0, 4'h0, 1'b0);
            cyc(1'b1, 8'hA0 + 8'((g + 3) % 4), 4'(1 << ((g + 3) % 4)), 1'b1);
        end
        req = '0;
        last = '0;
        cyc(1'b0, 8'h0, 4'h0, 1'b0);
        chk("rr_owner", 32'(owner), 32'd3);

        // MAXBURST cap: requesters 1 and 3, no last
        req = 4'b1010;
        cyc(1'b0, 8'h0, 4'h0, 1'b0);
        for (int b = 0; b < MAXBURST; b++) begin
            setd(1, 8'h10 + 8'(b));
            cyc(1'b1, 8'h10 + 8'(b), 4'b0010, 1'b1);
        end
        cyc(1'b0, 8'h0, 4'h0, 1'b0);
        for (int b = 0; b < MAXBURST; b++) begin
            setd(3, 8'h30 + 8'(b));
            cyc(1'b1, 8'h30 + 8'(b), 4'b1000, 1'b1);
        end
        req = '0;
        cyc(1'b0, 8'h0, 4'h0, 1'b0);

        // Full stall mid-burst on requester 0; bcnt must hold across the stall
        req = 4'b0001;
        cyc(1'b0, 8'h0, 4'h0, 1'b0);
        setd(0, 8'h76);
        cyc(1'b1, 8'h76, 4'b0001, 1'b1);
        setd(0, 8'h77);
        cyc(1'b1, 8'h77, 4'b0001, 1'b1);
        setd(0, 8'h78);
        full = 1'b1;
        repeat (3) cyc(1'b0, 8'h0, 4'h0, 1'b1);
        full = 1'b0;
        cyc(1'b1, 8'h78, 4'b0001, 1'b1);
        setd(0, 8'h79);
        cyc(1'b1, 8'h79, 4'b0001, 1'b1);
        cyc(1'b0, 8'h0, 4'h0, 1'b0);
        setd(0, 8'h7A);
        last = 4'b0001;
        cyc(1'b1, 8'h7A, 4'b0001, 1'b1);
        last = '0;

        // Overflow sticky, then request drop coinciding with full
        cyc(1'b0, 8'h0, 4'h0, 1'b0);
        setd(0, 8'h55);
        overflow = 1'b1;
        chk("err_before", 32'(err_ovfl), 32'd0);
        cyc(1'b1, 8'h55, 4'b0001, 1'b1);
        overflow = 1'b0;
        chk("err_set", 32'(err_ovfl), 32'd1);
        setd(0, 8'h56);
        cyc(1'b1, 8'h56, 4'b0001, 1'b1);
        chk("err_sticky", 32'(err_ovfl), 32'd1);
        req = '0;
        full = 1'b1;
        cyc(1'b0, 8'h0, 4'h0, 1'b1);
        full = 1'b0;
        cyc(1'b0, 8'h0, 4'h0, 1'b0);

        // Asynchronous reset in the middle of a burst
        req = 4'b0001;
        setd(0, 8'h57);
        cyc(1'b0, 8'h0, 4'h0, 1'b0);
        #1;
        chk("pre_rst_w_en", 32'(w_en), 32'd1);
        chk("pre_rst_din", 32'(din), 32'h57);
        rst = 1'b0;
        #1;
        chk("async_w_en", 32'(w_en), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_err", 32'(err_ovfl), 32'd0);
        chk("async_ack", 32'(ack), 32'd0);
        chk("async_din", 32'(din), 32'd0);
        @(negedge clk);
        chk("rst_hold_w_en", 32'(w_en), 32'd0);
        rst = 1'b1;
        req = '0;
        cyc(1'b0, 8'h0, 4'h0, 1'b0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
